// File: rtl/arp_reply_tx_pkg.sv
// Shared ARP constants, FSM state type and byte-extract helpers.
// Used by the reply transmitter and the request detector.
package arp_reply_tx_pkg;

    localparam logic [15:0] ARP_ETHERTYPE = 16'h0806;
    localparam logic [15:0] HTYPE_ETH     = 16'h0001;
    localparam logic [15:0] PTYPE_IPV4    = 16'h0800;
    localparam logic [7:0]  HLEN          = 8'd6;
    localparam logic [7:0]  PLEN          = 8'd4;
    localparam logic [15:0] OP_REQ        = 16'd1;
    localparam logic [15:0] OP_REPLY      = 16'd2;
    localparam int          ARP_FRAME_LEN = 42;
    localparam int          ETH_MIN_LEN   = 60;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_SEND,
        ST_PAD,
        ST_GAP
    } state_t;

    // k = 0 selects the most significant (first transmitted) byte
    function automatic logic [7:0] mac_byte(input logic [47:0] v,
                                            input logic [5:0]  k);
        return 8'(v >> (8 * (5 - int'(k))));
    endfunction

    function automatic logic [7:0] ip_byte(input logic [31:0] v,
                                           input logic [5:0]  k);
        return 8'(v >> (8 * (3 - int'(k))));
    endfunction

endpackage

// File: rtl/arp_reply_tx_byte_sel.sv
// Maps a frame byte index plus the frozen address fields to the
// byte transmitted at that index; indices past the ARP body are pad.
module arp_reply_tx_byte_sel
    import arp_reply_tx_pkg::*;
(
    input  logic [5:0]  i_idx,
    input  logic [47:0] i_src_mac,
    input  logic [31:0] i_src_ip,
    input  logic [47:0] i_my_mac,
    input  logic [31:0] i_my_ip,
    output logic [7:0]  o_byte
);

    always_comb begin
        o_byte = 8'h00;
        unique case (1'b1)
            (i_idx inside {[6'd0:6'd5]}):
                o_byte = mac_byte(i_src_mac, i_idx);
            (i_idx inside {[6'd6:6'd11]}):
                o_byte = mac_byte(i_my_mac, i_idx - 6'd6);
            (i_idx inside {[6'd12:6'd13]}):
                o_byte = i_idx[0] ? ARP_ETHERTYPE[7:0]
                                  : ARP_ETHERTYPE[15:8];
            (i_idx inside {[6'd14:6'd15]}):
                o_byte = i_idx[0] ? HTYPE_ETH[7:0] : HTYPE_ETH[15:8];
            (i_idx inside {[6'd16:6'd17]}):
                o_byte = i_idx[0] ? PTYPE_IPV4[7:0] : PTYPE_IPV4[15:8];
            (i_idx == 6'd18):
                o_byte = HLEN;
            (i_idx == 6'd19):
                o_byte = PLEN;
            (i_idx inside {[6'd20:6'd21]}):
                o_byte = i_idx[0] ? OP_REPLY[7:0] : OP_REPLY[15:8];
            (i_idx inside {[6'd22:6'd27]}):
                o_byte = mac_byte(i_my_mac, i_idx - 6'd22);
            (i_idx inside {[6'd28:6'd31]}):
                o_byte = ip_byte(i_my_ip, i_idx - 6'd28);
            (i_idx inside {[6'd32:6'd37]}):
                o_byte = mac_byte(i_src_mac, i_idx - 6'd32);
            (i_idx inside {[6'd38:6'd41]}):
                o_byte = ip_byte(i_src_ip, i_idx - 6'd38);
            default:
                o_byte = 8'h00;
        endcase
    end

endmodule

// File: rtl/arp_reply_tx.sv
// ARP reply serialiser: captures a detected request and streams the
// reply frame one byte per accepted beat, then holds off for the IFG.
module arp_reply_tx
    import arp_reply_tx_pkg::*;
#(
    parameter bit PAD_EN     = 1'b1,
    parameter int IFG_CYCLES = 12
)
(
    input  logic        clk,
    input  logic        areset_n,
    input  logic [47:0] my_mac,
    input  logic [31:0] my_ip,
    input  logic        arp_send,
    input  logic [47:0] source_mac,
    input  logic [31:0] source_ip,
    input  logic        tx_ready,
    output logic        tx_valid,
    output logic [7:0]  tx_data,
    output logic        tx_last,
    output logic        busy,
    output logic [7:0]  drop_cnt
);

    localparam logic [5:0] LAST_IDX = PAD_EN ? 6'(ETH_MIN_LEN - 1)
                                             : 6'(ARP_FRAME_LEN - 1);
    localparam logic [15:0] GAP_INIT = (IFG_CYCLES > 0)
                                     ? 16'(IFG_CYCLES - 1) : 16'd0;

    state_t      r_state;
    logic [5:0]  r_idx;
    logic [15:0] r_gap;
    logic        r_arp_send_d;
    logic [47:0] r_src_mac;
    logic [31:0] r_src_ip;
    logic [47:0] r_my_mac;
    logic [31:0] r_my_ip;
    logic        r_tx_valid;
    logic [7:0]  r_tx_data;
    logic        r_tx_last;
    logic        r_busy;
    logic [7:0]  r_drop;

    logic        w_trig;
    logic        w_acc;
    logic        w_idle;
    logic [5:0]  w_idx_nxt;
    logic [5:0]  w_sel_idx;
    logic [47:0] w_src_mac;
    logic [31:0] w_src_ip;
    logic [47:0] w_my_mac;
    logic [31:0] w_my_ip;
    logic [7:0]  w_byte;

    assign w_trig    = arp_send & ~r_arp_send_d;
    assign w_acc     = r_tx_valid & tx_ready;
    assign w_idle    = (r_state == ST_IDLE);
    assign w_idx_nxt = r_idx + 6'd1;

    // In IDLE the selector looks at live inputs so byte 0 is ready
    // on the very edge that captures them.
    assign w_sel_idx = w_idle ? 6'd0 : w_idx_nxt;
    assign w_src_mac = w_idle ? source_mac : r_src_mac;
    assign w_src_ip  = w_idle ? source_ip  : r_src_ip;
    assign w_my_mac  = w_idle ? my_mac     : r_my_mac;
    assign w_my_ip   = w_idle ? my_ip      : r_my_ip;

    arp_reply_tx_byte_sel u_byte_sel (
        .i_idx     (w_sel_idx),
        .i_src_mac (w_src_mac),
        .i_src_ip  (w_src_ip),
        .i_my_mac  (w_my_mac),
        .i_my_ip   (w_my_ip),
        .o_byte    (w_byte)
    );

    always_ff @(posedge clk or negedge areset_n) begin
        if (!areset_n) begin
            r_state      <= ST_IDLE;
            r_idx        <= 6'd0;
            r_gap        <= 16'd0;
            r_arp_send_d <= 1'b0;
            r_src_mac    <= 48'd0;
            r_src_ip     <= 32'd0;
            r_my_mac     <= 48'd0;
            r_my_ip      <= 32'd0;
            r_tx_valid   <= 1'b0;
            r_tx_data    <= 8'h00;
            r_tx_last    <= 1'b0;
            r_busy       <= 1'b0;
            r_drop       <= 8'd0;
        end else begin
            r_arp_send_d <= arp_send;
            if (w_trig && !w_idle && r_drop != 8'hFF)
                r_drop <= r_drop + 8'd1;
            unique case (r_state)
                ST_IDLE: begin
                    if (w_trig) begin
                        r_src_mac  <= source_mac;
                        r_src_ip   <= source_ip;
                        r_my_mac   <= my_mac;
                        r_my_ip    <= my_ip;
                        r_idx      <= 6'd0;
                        r_tx_valid <= 1'b1;
                        r_tx_data  <= w_byte;
                        r_tx_last  <= 1'b0;
                        r_busy     <= 1'b1;
                        r_state    <= ST_SEND;
                    end
                end
                ST_SEND, ST_PAD: begin
                    if (w_acc) begin
                        if (r_idx == LAST_IDX) begin
                            r_tx_valid <= 1'b0;
                            r_tx_data  <= 8'h00;
                            r_tx_last  <= 1'b0;
                            if (IFG_CYCLES == 0) begin
                                r_busy  <= 1'b0;
                                r_state <= ST_IDLE;
                            end else begin
                                r_gap   <= GAP_INIT;
                                r_state <= ST_GAP;
                            end
                        end else begin
                            r_idx     <= w_idx_nxt;
                            r_tx_data <= w_byte;
                            r_tx_last <= (w_idx_nxt == LAST_IDX);
                            if (w_idx_nxt >= 6'(ARP_FRAME_LEN))
                                r_state <= ST_PAD;
                        end
                    end
                end
                ST_GAP: begin
                    if (r_gap == 16'd0) begin
                        r_busy  <= 1'b0;
                        r_state <= ST_IDLE;
                    end else begin
                        r_gap <= r_gap - 16'd1;
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign tx_valid = r_tx_valid;
    assign tx_data  = r_tx_data;
    assign tx_last  = r_tx_last;
    assign busy     = r_busy;
    assign drop_cnt = r_drop;

endmodule

// File: tb/tb_arp_reply_tx.sv
// Self-checking bench for arp_reply_tx: padded/IFG=12 instance plus an
// unpadded/IFG=0 instance, checked against a frame model built from fields.
module tb_arp_reply_tx;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        areset_n;
    logic [47:0] my_mac, source_mac;
    logic [31:0] my_ip, source_ip;
    logic        arp_send, tx_ready;
    logic        tx_valid, tx_last, busy;
    logic [7:0]  tx_data, drop_cnt;

    logic        send0, ready0;
    logic        v0, l0, b0;
    logic [7:0]  d0, dc0;

    arp_reply_tx #(.PAD_EN(1'b1), .IFG_CYCLES(12)) u_dut (
        .clk(clk), .areset_n(areset_n),
        .my_mac(my_mac), .my_ip(my_ip),
        .arp_send(arp_send), .source_mac(source_mac), .source_ip(source_ip),
        .tx_ready(tx_ready), .tx_valid(tx_valid), .tx_data(tx_data),
        .tx_last(tx_last), .busy(busy), .drop_cnt(drop_cnt)
    );

    arp_reply_tx #(.PAD_EN(1'b0), .IFG_CYCLES(0)) u_dut0 (
        .clk(clk), .areset_n(areset_n),
        .my_mac(my_mac), .my_ip(my_ip),
        .arp_send(send0), .source_mac(source_mac), .source_ip(source_ip),
        .tx_ready(ready0), .tx_valid(v0), .tx_data(d0),
        .tx_last(l0), .busy(b0), .drop_cnt(dc0)
    );

    logic       sel;
    logic       c_valid, c_last;
    logic [7:0] c_data;
    assign c_valid = sel ? v0 : tx_valid;
    assign c_last  = sel ? l0 : tx_last;
    assign c_data  = sel ? d0 : tx_data;

    int npass = 0;
    int ntot  = 0;
    logic [7:0] ref_q[$];
    logic [7:0] got_q[$];
    int         last_pos[$];

    typedef struct {
        int         idx;
        logic [7:0] b;
    } vec_t;
    vec_t tab[15];

    task automatic chk(input string nm, input logic [63:0] got,
                       input logic [63:0] exp);
        ntot++;
        if (got === exp) npass++;
        else $display("FAIL %s: got %0h required %0h", nm, got, exp);
    endtask

    // Reference frame: the header fields concatenated in wire order,
    // then zero padding up to len bytes.
    function automatic void build_ref(input logic [47:0] smac,
                                      input logic [31:0] sip,
                                      input logic [47:0] mmac,
                                      input logic [31:0] mip,
                                      input int len);
        logic [335:0] hdr;
        hdr = {smac, mmac, 16'h0806, 16'h0001, 16'h0800, 8'h06, 8'h04,
               16'h0002, mmac, mip, smac, sip};
        ref_q.delete();
        for (int i = 0; i < 42; i++) ref_q.push_back(hdr[335 - 8*i -: 8]);
        for (int i = 42; i < len; i++) ref_q.push_back(8'h00);
    endfunction

    // Called at a negedge where the first byte is already presented.
    task automatic collect(input int mode, input int maxcyc,
                           output int ncyc);
        logic pv, pr, pl, r;
        logic [7:0] pd;
        bit done;
        pv = 0; pr = 0; pl = 0; pd = 0; done = 0; ncyc = 0;
        got_q.delete();
        last_pos.delete();
        for (int c = 0; c < maxcyc && !done; c++) begin
            case (mode)
                0:       r = 1'b1;
                1:       r = (c % 2 == 1);
                default: r = 1'($urandom_range(0, 1));
            endcase
            tx_ready = r;
            ready0   = r;
            if (pv && !pr)
                chk("hold", {c_valid, c_last, c_data}, {pv, pl, pd});
            else if (pv && pr && !pl)
                chk("stream valid", c_valid, 1);
            if (c_valid && r) begin
                got_q.push_back(c_data);
                if (c_last) begin
                    last_pos.push_back(got_q.size() - 1);
                    done = 1;
                    ncyc = c + 1;
                end
            end
            pv = c_valid; pr = r; pl = c_last; pd = c_data;
            if (!done) @(negedge clk);
        end
        if (!done) chk("collect timeout", 0, 1);
    endtask

    task automatic cmp_frame(input string nm, input int len);
        int errs;
        errs = 0;
        chk({nm, " len"}, got_q.size(), len);
        for (int i = 0; i < got_q.size() && i < ref_q.size(); i++)
            if (got_q[i] !== ref_q[i]) errs++;
        chk({nm, " bytes"}, errs, 0);
        chk({nm, " last pos"},
            (last_pos.size() == 1 && last_pos[0] == len - 1), 1);
    endtask

    task automatic count_busy(output int k);
        k = 0;
        for (int c = 0; c < 200; c++) begin
            @(negedge clk);
            if (!busy) break;
            k++;
        end
    endtask

    task automatic rand_fields();
        source_mac = {16'($urandom), 32'($urandom)};
        source_ip  = 32'($urandom);
        my_mac     = {16'($urandom), 32'($urandom)};
        my_ip      = 32'($urandom);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int n, k;
        logic [47:0] s_smac, s_mmac;
        logic [31:0] s_sip, s_mip;

        tab = '{'{0, 8'h0A}, '{5, 8'h0F}, '{6, 8'h02}, '{11, 8'h01},
                '{12, 8'h08}, '{13, 8'h06}, '{20, 8'h00}, '{21, 8'h02},
                '{28, 8'hC0}, '{29, 8'hA8}, '{30, 8'h01}, '{31, 8'h01},
                '{32, 8'h0A}, '{41, 8'h05}, '{59, 8'h00}};

        sel = 0; areset_n = 0; arp_send = 0; send0 = 0;
        tx_ready = 0; ready0 = 0;
        source_mac = 0; source_ip = 0; my_mac = 0; my_ip = 0;
        repeat (3) @(negedge clk);
        chk("rst tx_valid", tx_valid, 0);
        chk("rst tx_data", tx_data, 0);
        chk("rst tx_last", tx_last, 0);
        chk("rst busy", busy, 0);
        chk("rst drop_cnt", drop_cnt, 0);
        @(negedge clk) areset_n = 1;
        @(negedge clk);

        // Single request, always ready
        source_mac = 48'h0A0B0C0D0E0F; source_ip = 32'hC0A80105;
        my_mac     = 48'h020000000001; my_ip     = 32'hC0A80101;
        arp_send = 1;
        @(negedge clk) arp_send = 0;
        chk("t1 latency valid", tx_valid, 1);
        chk("t1 busy", busy, 1);
        build_ref(source_mac, source_ip, my_mac, my_ip, 60);
        collect(0, 200, n);
        cmp_frame("t1", 60);
        chk("t1 cycles", n, 60);
        for (int i = 0; i < 15; i++)
            chk($sformatf("t1 idx%0d", tab[i].idx), got_q[tab[i].idx], tab[i].b);
        count_busy(k);
        chk("t1 ifg", k, 12);

        // Backpressure: ready alternates starting low
        arp_send = 1;
        @(negedge clk) arp_send = 0;
        collect(1, 400, n);
        cmp_frame("t2", 60);
        chk("t2 cycles", n, 120);
        count_busy(k);
        chk("t2 ifg", k, 12);

        // Long arp_send level with random ready
        for (int it = 0; it < 4; it++) begin
            rand_fields();
            build_ref(source_mac, source_ip, my_mac, my_ip, 60);
            arp_send = 1;
            fork
                begin repeat (5) @(negedge clk); arp_send = 0; end
                begin @(negedge clk); collect(2, 1000, n); end
            join
            cmp_frame($sformatf("t3.%0d", it), 60);
            count_busy(k);
            chk("t3 ifg", k, 12);
            chk("t3 no refire", tx_valid, 0);
            chk("t3 drop_cnt", drop_cnt, 0);
        end

        // Edges mid-frame and during the gap are dropped
        rand_fields();
        s_smac = source_mac; s_sip = source_ip; s_mmac = my_mac; s_mip = my_ip;
        build_ref(s_smac, s_sip, s_mmac, s_mip, 60);
        arp_send = 1;
        @(negedge clk) arp_send = 0;
        fork
            collect(0, 200, n);
            begin
                repeat (10) @(negedge clk);
                arp_send = 1;
                source_mac = ~s_smac; source_ip = ~s_sip;
                my_mac = ~s_mmac; my_ip = ~s_mip;
                @(negedge clk) arp_send = 0;
            end
        join
        cmp_frame("t4", 60);
        k = 0;
        for (int c = 0; c < 200; c++) begin
            @(negedge clk);
            if (c == 3) arp_send = 1;
            if (c == 4) arp_send = 0;
            if (!busy) break;
            k++;
        end
        chk("t4 ifg", k, 12);
        chk("t4 drop_cnt", drop_cnt, 2);

        // Reset mid-frame, arp_send high across release
        rand_fields();
        build_ref(source_mac, source_ip, my_mac, my_ip, 60);
        tx_ready = 1;
        arp_send = 1;
        @(negedge clk) arp_send = 0;
        repeat (25) @(negedge clk);
        chk("t5 byte25", tx_data, ref_q[25]);
        areset_n = 0;
        #1;
        chk("t5 rst valid", tx_valid, 0);
        chk("t5 rst last", tx_last, 0);
        chk("t5 rst busy", busy, 0);
        chk("t5 rst drop", drop_cnt, 0);
        rand_fields();
        build_ref(source_mac, source_ip, my_mac, my_ip, 60);
        arp_send = 1;
        @(negedge clk) areset_n = 1;
        @(negedge clk) arp_send = 0;
        chk("t5 restart valid", tx_valid, 1);
        collect(0, 200, n);
        cmp_frame("t5", 60);
        count_busy(k);
        chk("t5 drop_cnt", drop_cnt, 0);

        // Unpadded, zero-IFG instance with back-to-back requests
        sel = 1;
        rand_fields();
        build_ref(source_mac, source_ip, my_mac, my_ip, 42);
        send0 = 1;
        @(negedge clk) send0 = 0;
        chk("t6 latency valid", v0, 1);
        collect(0, 200, n);
        cmp_frame("t6a", 42);
        chk("t6 cycles", n, 42);
        @(negedge clk);
        chk("t6 idle busy", b0, 0);
        chk("t6 idle valid", v0, 0);
        rand_fields();
        build_ref(source_mac, source_ip, my_mac, my_ip, 42);
        send0 = 1;
        @(negedge clk) send0 = 0;
        chk("t6 b2b valid", v0, 1);
        collect(0, 200, n);
        cmp_frame("t6b", 42);
        chk("t6 drop_cnt", dc0, 0);

        $display("%0d/%0d checks passed", npass, ntot);
        $finish;
    end

endmodule
